// File: rtl/demux_1x2_sched_if.sv
// Handshake bundle for the 1-to-2 burst demux: one upstream word stream,
// two downstream channels, plus mode/select controls and status.
interface demux_1x2_sched_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;
  logic              mode;
  logic              s;
  logic [DATA_W-1:0] y0;
  logic              y0_valid;
  logic              y0_ready;
  logic [DATA_W-1:0] y1;
  logic              y1_valid;
  logic              y1_ready;
  logic              cur_sel;
  logic              busy;
  logic              burst_done;

  // Producer/consumer side: drives words, controls and channel readies.
  modport master (
    output din, din_valid, mode, s, y0_ready, y1_ready,
    input  din_ready, y0, y0_valid, y1, y1_valid, cur_sel, busy, burst_done
  );

  // Scheduler side.
  modport slave (
    input  din, din_valid, mode, s, y0_ready, y1_ready,
    output din_ready, y0, y0_valid, y1, y1_valid, cur_sel, busy, burst_done
  );
endinterface

// File: rtl/demux_1x2_sched.sv
// Burst scheduler for a 1-to-2 demux. Each burst of BURST_LEN words is
// routed atomically to one channel, picked in IDLE from the external select
// or a round-robin pointer. A single output register serves both channels.
module demux_1x2_sched #(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             rst,
  demux_1x2_sched_if.slave bus
);
  localparam int               CNT_W    = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUTE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              out_valid_q, out_valid_d;
  logic              cur_sel_q, cur_sel_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              burst_done_q, burst_done_d;

  logic              sel_ready;
  logic              out_hs;
  logic              in_hs;
  logic              din_ready;
  logic [1:0]        ch_ready;
  logic [1:0]        ch_valid;
  logic [DATA_W-1:0] ch_data [2];

  // Only the selected channel's ready matters; the other one is ignored.
  assign ch_ready  = {bus.y1_ready, bus.y0_ready};
  assign sel_ready = ch_ready[cur_sel_q];
  assign out_hs    = out_valid_q && sel_ready;
  // Accept a new word when the output register is empty or draining this cycle.
  assign din_ready = (state_q == ROUTE) && (!out_valid_q || sel_ready);
  assign in_hs     = bus.din_valid && din_ready;

  // Steer the shared output register to the latched channel; the other is held at zero.
  for (genvar gi = 0; gi < 2; gi++) begin : g_ch
    assign ch_valid[gi] = out_valid_q && (cur_sel_q == 1'(gi));
    assign ch_data[gi]  = ch_valid[gi] ? data_q : '0;
  end

  assign bus.din_ready  = din_ready;
  assign bus.y0         = ch_data[0];
  assign bus.y0_valid   = ch_valid[0];
  assign bus.y1         = ch_data[1];
  assign bus.y1_valid   = ch_valid[1];
  assign bus.cur_sel    = cur_sel_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.burst_done = burst_done_q;

  // Next-state logic for the FSM, word counter, output register and round-robin pointer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    out_valid_d  = out_valid_q;
    cur_sel_d    = cur_sel_q;
    rr_ptr_d     = rr_ptr_q;
    burst_done_d = 1'b0;

    if (in_hs) begin
      data_d      = bus.din;
      out_valid_d = 1'b1;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // mode and s are only looked at here, so mid-burst changes cannot split a burst.
        if (bus.din_valid) begin
          cur_sel_d = bus.mode ? rr_ptr_q : bus.s;
          cnt_d     = '0;
          state_d   = ROUTE;
        end
      end
      ROUTE: begin
        if (in_hs) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Wait for the last word to leave before releasing the channel.
        if (!out_valid_q || out_hs) begin
          state_d      = IDLE;
          burst_done_d = 1'b1;
          if (bus.mode) begin
            rr_ptr_d = ~rr_ptr_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any buffered word and the rest of the burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      data_q       <= '0;
      out_valid_q  <= 1'b0;
      cur_sel_q    <= 1'b0;
      rr_ptr_q     <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      out_valid_q  <= out_valid_d;
      cur_sel_q    <= cur_sel_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_done_q <= burst_done_d;
    end
  end
endmodule

// File: tb/tb_demux_1x2_sched.sv
// Bench for demux_1x2_sched: directed timing scenarios plus randomized
// segments, all checked against a transaction-level burst model.
module tb_demux_1x2_sched;
  localparam int BL = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  demux_1x2_sched_if #(.DATA_W(8)) bus ();
  demux_1x2_sched_if #(.DATA_W(8)) bus1 ();

  demux_1x2_sched #(.DATA_W(8), .BURST_LEN(BL)) dut (.clk(clk), .rst(rst), .bus(bus));
  demux_1x2_sched #(.DATA_W(8), .BURST_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: expected output words in order with their channel.
  typedef struct packed {
    logic       dest;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];
  int   idx;
  logic rr;
  logic mdl_dest;
  int   bursts_started;
  int   done_cnt;
  logic prev_ok;
  logic prev_sel;
  logic prev_busy;
  logic hs_s;
  logic hs1_s;
  int   sent;
  int   guard;
  int   nwords;
  int   cnt0;
  int   cnt1;
  int   acc_cyc[4];
  logic acc_sel[4];
  logic pend;
  logic pend_sel;
  logic [7:0] pend_word;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Scoreboard step for the BURST_LEN=4 instance, called once per cycle.
  task automatic monitor_step();
    logic [1:0] yv;
    logic [1:0] yr;
    logic [7:0] yd [2];
    yv    = {bus.y1_valid, bus.y0_valid};
    yr    = {bus.y1_ready, bus.y0_ready};
    yd[0] = bus.y0;
    yd[1] = bus.y1;
    if (rst) begin
      exp_q.delete();
      idx = 0;
      rr = 1'b0;
      bursts_started = 0;
      done_cnt = 0;
      prev_ok = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (yv[k]) begin
          if (exp_q.size() == 0) begin
            check_val("sb_extra", 32'(yv[k]), 0);
          end else begin
            check_val("sb_dest", k, 32'(exp_q[0].dest));
            check_val("sb_data", 32'(yd[k]), 32'(exp_q[0].data));
            if (yr[k]) void'(exp_q.pop_front());
          end
        end else begin
          check_val("y_idle_data", 32'(yd[k]), 0);
        end
      end
      if (prev_ok && (bus.cur_sel != prev_sel)) check_val("sel_in_idle", 32'(prev_busy), 0);
      if (bus.din_valid && bus.din_ready) begin
        if (idx == 0) begin
          mdl_dest = bus.mode ? rr : bus.s;
          if (bus.mode) rr = ~rr;
          bursts_started++;
        end
        exp_q.push_back('{dest: mdl_dest, data: bus.din});
        idx = (idx + 1) % BL;
      end
      if (bus.burst_done) done_cnt++;
      prev_sel  = bus.cur_sel;
      prev_busy = bus.busy;
      prev_ok   = 1'b1;
    end
  endtask

  task automatic sample();
    @(negedge clk);
    monitor_step();
    hs_s  = bus.din_valid && bus.din_ready;
    hs1_s = bus1.din_valid && bus1.din_ready;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_val(tag, {bus.din_ready, bus.busy, bus.y0_valid, bus.y1_valid, bus.cur_sel,
                    bus.burst_done, bus.y0, bus.y1}, 0);
  endtask

  task automatic do_reset();
    bus.din_valid  = 1'b0;
    bus1.din_valid = 1'b0;
    rst = 1'b1;
    advance();
    sample();
    check_all_zero("reset_outputs");
    advance();
    rst = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    bus.din_valid = 1'b0;
    bus.y0_ready  = 1'b1;
    bus.y1_ready  = 1'b1;
    repeat (BL + 6) begin
      sample();
      advance();
    end
    check_val({tag, "_sb_left"}, exp_q.size(), 0);
    check_val({tag, "_done_cnt"}, done_cnt, bursts_started);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idx = 0; rr = 1'b0; mdl_dest = 1'b0; bursts_started = 0; done_cnt = 0;
    prev_ok = 1'b0; prev_sel = 1'b0; prev_busy = 1'b0;
    bus.din = '0; bus.din_valid = 1'b0; bus.mode = 1'b0; bus.s = 1'b0;
    bus.y0_ready = 1'b1; bus.y1_ready = 1'b1;
    bus1.din = '0; bus1.din_valid = 1'b0; bus1.mode = 1'b0; bus1.s = 1'b0;
    bus1.y0_ready = 1'b1; bus1.y1_ready = 1'b1;
    advance();

    // Fixed select, mode 0: burst 0x11..0x14 to y1.
    do_reset();
    bus.mode = 1'b0; bus.s = 1'b1; bus.din = 8'h11; bus.din_valid = 1'b1; sent = 0;
    for (int c = 0; c < 9; c++) begin
      sample();
      check_val("t1_y0_valid", 32'(bus.y0_valid), 0);
      check_val("t1_y0_data", 32'(bus.y0), 0);
      check_val("t1_y1_valid", 32'(bus.y1_valid), 32'(c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) check_val("t1_y1_data", 32'(bus.y1), 32'h11 + c - 2);
      check_val("t1_done", 32'(bus.burst_done), 32'(c == 6));
      if (hs_s) sent++;
      advance();
      if (sent < BL) bus.din = 8'h11 + 8'(sent); else bus.din_valid = 1'b0;
    end
    drain_and_check("t1");

    // Round-robin: three back-to-back bursts with din_valid held high.
    do_reset();
    bus.mode = 1'b1; bus.din = 8'h31; bus.din_valid = 1'b1; sent = 0;
    for (int c = 0; c < 100 && sent < 3 * BL; c++) begin
      sample();
      if (hs_s) begin
        if (sent % BL == 0) begin
          acc_cyc[sent / BL] = c;
          acc_sel[sent / BL] = bus.cur_sel;
        end
        sent++;
      end
      advance();
      if (sent < 3 * BL) bus.din = 8'h31 + 8'(sent); else bus.din_valid = 1'b0;
    end
    check_val("t2_words", sent, 3 * BL);
    check_val("t2_sel0", 32'(acc_sel[0]), 0);
    check_val("t2_sel1", 32'(acc_sel[1]), 1);
    check_val("t2_sel2", 32'(acc_sel[2]), 0);
    check_val("t2_period1", acc_cyc[1] - acc_cyc[0], BL + 2);
    check_val("t2_period2", acc_cyc[2] - acc_cyc[1], BL + 2);
    drain_and_check("t2");

    // Backpressure: y0_ready low for 3 cycles while word 0x22 is buffered.
    do_reset();
    bus.mode = 1'b0; bus.s = 1'b0; bus.din = 8'h21; bus.din_valid = 1'b1; sent = 0;
    for (int c = 0; c < 12; c++) begin
      bus.y0_ready = !(c >= 3 && c <= 5);
      sample();
      if (c >= 3 && c <= 5) begin
        check_val("t3_din_ready", 32'(bus.din_ready), 0);
        check_val("t3_hold_data", 32'(bus.y0), 32'h22);
        check_val("t3_hold_valid", 32'(bus.y0_valid), 1);
      end
      check_val("t3_done", 32'(bus.burst_done), 32'(c == 9));
      if (hs_s) sent++;
      advance();
      if (sent < BL) bus.din = 8'h21 + 8'(sent); else bus.din_valid = 1'b0;
    end
    drain_and_check("t3");

    // Select toggles mid-burst: first burst stays on y0, next burst follows new s=1.
    do_reset();
    bus.mode = 1'b0; bus.s = 1'b0; bus.din = 8'h41; bus.din_valid = 1'b1;
    sent = 0; cnt0 = 0; cnt1 = 0;
    for (int c = 0; c < 80 && sent < 2 * BL; c++) begin
      sample();
      if (bus.y0_valid && bus.y0_ready) cnt0++;
      if (bus.y1_valid && bus.y1_ready) cnt1++;
      if (hs_s) sent++;
      advance();
      if (sent >= 1 && sent < BL) bus.s = ~bus.s;
      else if (sent >= BL) bus.s = 1'b1;
      if (sent < 2 * BL) bus.din = 8'h41 + 8'(sent); else bus.din_valid = 1'b0;
    end
    repeat (BL + 4) begin
      sample();
      if (bus.y0_valid && bus.y0_ready) cnt0++;
      if (bus.y1_valid && bus.y1_ready) cnt1++;
      advance();
    end
    check_val("t4_y0_words", cnt0, BL);
    check_val("t4_y1_words", cnt1, BL);
    drain_and_check("t4");

    // Reset after word 2 of a y1 burst, then a full burst to y0 in mode 1.
    do_reset();
    bus.mode = 1'b1; bus.din = 8'h51; bus.din_valid = 1'b1; sent = 0;
    for (int c = 0; c < 60 && sent < BL + 2; c++) begin
      sample();
      if (hs_s) sent++;
      advance();
      bus.din = 8'h51 + 8'(sent);
    end
    check_val("t5_pre_words", sent, BL + 2);
    check_val("t5_pre_sel", 32'(bus.cur_sel), 1);
    bus.din_valid = 1'b0;
    rst = 1'b1;
    sample();
    advance();
    rst = 1'b0;
    sample();
    check_all_zero("t5_after_rst");
    advance();
    bus.din = 8'h61; bus.din_valid = 1'b1; sent = 0; pend = 1'b0;
    for (int c = 0; c < 40 && !pend; c++) begin
      sample();
      if (bus.burst_done) begin
        pend = 1'b1;
        check_val("t5_words_at_done", sent, BL);
      end
      if (hs_s) begin
        if (sent == 0) check_val("t5_sel", 32'(bus.cur_sel), 0);
        sent++;
      end
      advance();
      if (sent < BL) bus.din = 8'h61 + 8'(sent); else bus.din_valid = 1'b0;
    end
    check_val("t5_done_seen", 32'(pend), 1);
    drain_and_check("t5");

    // Randomized segments; mode changes only between quiescent segments.
    do_reset();
    for (int seg = 0; seg < 8; seg++) begin
      bus.mode = 1'($urandom_range(0, 1));
      bus.s    = 1'($urandom_range(0, 1));
      nwords   = BL * int'($urandom_range(2, 5));
      sent     = 0;
      guard    = 0;
      bus.din_valid = 1'b0;
      while (sent < nwords && guard < 2000) begin
        if (!bus.din_valid && $urandom_range(0, 3) != 0) begin
          bus.din_valid = 1'b1;
          bus.din = 8'($urandom);
        end
        bus.y0_ready = ($urandom_range(0, 3) != 0);
        bus.y1_ready = ($urandom_range(0, 3) != 0);
        if (idx >= 1 && idx <= BL - 1 && $urandom_range(0, 1) == 1) bus.s = ~bus.s;
        sample();
        if (hs_s) sent++;
        advance();
        guard++;
        if (hs_s) bus.din_valid = 1'b0;
      end
      check_val("rnd_seg_words", sent, nwords);
      drain_and_check("rnd");
    end

    // BURST_LEN=1 instance: each word is a burst, alternating, period 3.
    do_reset();
    bus1.mode = 1'b1; bus1.din = 8'h71; bus1.din_valid = 1'b1; sent = 0; pend = 1'b0;
    for (int c = 0; c < 40 && (sent < 4 || pend); c++) begin
      sample();
      if (pend) begin
        check_val("bl1_valid", 32'(pend_sel ? bus1.y1_valid : bus1.y0_valid), 1);
        check_val("bl1_data", 32'(pend_sel ? bus1.y1 : bus1.y0), 32'(pend_word));
        check_val("bl1_other", 32'(pend_sel ? bus1.y0_valid : bus1.y1_valid), 0);
        pend = 1'b0;
      end
      if (hs1_s) begin
        acc_cyc[sent] = c;
        check_val("bl1_sel", 32'(bus1.cur_sel), sent % 2);
        if (sent > 0) check_val("bl1_period", acc_cyc[sent] - acc_cyc[sent - 1], 3);
        pend      = 1'b1;
        pend_sel  = bus1.cur_sel;
        pend_word = bus1.din;
        sent++;
      end
      advance();
      if (sent < 4) bus1.din = 8'h71 + 8'(sent); else bus1.din_valid = 1'b0;
    end
    check_val("bl1_words", sent, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
